// File: rtl/ll_list_builder.sv
// ll_list_builder: links incoming node pointers into singly linked lists.
// Each list is built in a next-pointer table as nodes arrive; when the last
// node of a list is accepted, the list's head pointer is queued in a small
// FIFO for the consumer, who can then walk the list through rd_ptr/rd_next.
module ll_list_builder #(
  parameter int unsigned N          = 256,
  parameter int unsigned W_PTR      = $clog2(N),
  parameter int unsigned HEAD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_PTR-1:0] in_ptr,
  input  logic             in_last,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [W_PTR-1:0] start,
  output logic             start_vld,
  input  logic             start_rdy,
  input  logic [W_PTR-1:0] rd_ptr,
  output logic [W_PTR-1:0] rd_next,
  output logic             err_null
);

  localparam int unsigned IDX_W = (HEAD_DEPTH > 1) ? $clog2(HEAD_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(HEAD_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(HEAD_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEAD_DEPTH - 1);

  typedef enum logic {
    IDLE,
    OPEN
  } state_t;

  state_t           state_q;
  logic [W_PTR-1:0] head_q;
  logic [W_PTR-1:0] tail_q;
  logic [W_PTR-1:0] next_q [N];
  logic [W_PTR-1:0] fifo_q [HEAD_DEPTH];
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_null_q;

  logic             full;
  logic             accept;
  logic             ptr_nz;
  logic             push;
  logic [W_PTR-1:0] push_val;
  logic             pop;

  // Wrap a FIFO index modulo HEAD_DEPTH.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Handshake, push/pop decode and combinational read ports.
  always_comb begin
    full      = (count_q == DEPTH_C);
    in_rdy    = ~full;
    accept    = in_vld & ~full;
    ptr_nz    = (in_ptr != '0);
    // A null last node still closes an open list, but never starts one.
    push      = accept & in_last & (ptr_nz | (state_q == OPEN));
    push_val  = (state_q == OPEN) ? head_q : in_ptr;
    start_vld = (count_q != '0);
    pop       = start_vld & start_rdy;
    start     = start_vld ? fifo_q[rd_idx_q] : '0;
    rd_next   = next_q[rd_ptr];
    err_null  = err_null_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // List-building FSM: tracks the open list's head and tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (ptr_nz) begin
            head_q <= in_ptr;
            tail_q <= in_ptr;
            if (!in_last) state_q <= OPEN;
          end
        end
        OPEN: begin
          if (ptr_nz) tail_q <= in_ptr;
          if (in_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next-pointer table; the terminating write on the new node comes last so
  // it wins when the new node equals the current tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) next_q[i] <= '0;
    end else if (accept && ptr_nz) begin
      if (state_q == OPEN) next_q[tail_q] <= in_ptr;
      next_q[in_ptr] <= '0;
    end
  end

  // Head FIFO storage (contents are only observed while count is nonzero).
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_idx_q] <= push_val;
  end

  // Head FIFO indices and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_idx_q <= idx_inc(wr_idx_q);
      if (pop)  rd_idx_q <= idx_inc(rd_idx_q);
      count_q <= count_d;
    end
  end

  // One-cycle flag after a null pointer is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_null_q <= 1'b0;
    else     err_null_q <= accept & ~ptr_nz;
  end

endmodule

// File: tb/tb_ll_list_builder.sv
// Directed bench for ll_list_builder with a queue-based reference model.
module tb_ll_list_builder;

  localparam int N = 256;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_ptr;
  logic         in_last;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] start;
  logic         start_vld;
  logic         start_rdy;
  logic [W-1:0] rd_ptr;
  logic [W-1:0] rd_next;
  logic         err_null;

  int checks = 0;
  int errors = 0;

  // Reference model: link table, queue of completed heads, open list nodes.
  int mnext [N];
  int mq[$];
  int cur[$];
  bit merr;

  ll_list_builder #(.N(N), .W_PTR(W), .HEAD_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_ptr    (in_ptr),
    .in_last   (in_last),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .start     (start),
    .start_vld (start_vld),
    .start_rdy (start_rdy),
    .rd_ptr    (rd_ptr),
    .rd_next   (rd_next),
    .err_null  (err_null)
  );

  initial begin
    clk = 1'b0;
    forever #30 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs held during it.
  task automatic model_update();
    bit acc;
    if (rst) begin
      foreach (mnext[i]) mnext[i] = 0;
      mq.delete();
      cur.delete();
      merr = 0;
      return;
    end
    acc = in_vld && (mq.size() < D);
    if (mq.size() != 0 && start_rdy) void'(mq.pop_front());
    merr = acc && (in_ptr == 0);
    if (acc) begin
      if (in_ptr != 0) begin
        if (cur.size() > 0) mnext[cur[cur.size()-1]] = int'(in_ptr);
        mnext[in_ptr] = 0;
        cur.push_back(int'(in_ptr));
      end
      if (in_last && cur.size() > 0) begin
        mq.push_back(cur[0]);
        cur.delete();
      end
    end
  endtask

  task automatic compare();
    check("in_rdy", {31'd0, in_rdy}, (mq.size() < D) ? 1 : 0);
    check("start_vld", {31'd0, start_vld}, (mq.size() != 0) ? 1 : 0);
    check("start", {24'd0, start}, (mq.size() != 0) ? mq[0] : 0);
    check("err_null", {31'd0, err_null}, {31'd0, merr});
    for (int a = 0; a < 16; a++) begin
      rd_ptr = W'(a);
      #1;
      check($sformatf("rd_next[%0d]", a), {24'd0, rd_next}, mnext[a]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input int p, input bit last);
    in_vld  = 1'b1;
    in_ptr  = W'(p);
    in_last = last;
    cycle();
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic lit_link(input int a, input int exp);
    rd_ptr = W'(a);
    #1;
    check($sformatf("lit_next[%0d]", a), {24'd0, rd_next}, exp);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_ptr = '0; in_last = 1'b0;
    start_rdy = 1'b0; rd_ptr = '0;
    cycle();
    cycle();
    check("lit_reset_start_vld", {31'd0, start_vld}, 0);
    rst = 1'b0;
    cycle();
    check("lit_in_rdy_after_rst", {31'd0, in_rdy}, 1);

    // 7 -> 15 -> 8
    send(7, 0); send(15, 0); send(8, 1);
    in_vld = 1'b0;
    check("lit031_start_vld", {31'd0, start_vld}, 1);
    check("lit031_start", {24'd0, start}, 7);
    lit_link(7, 15); lit_link(15, 8); lit_link(8, 0);
    start_rdy = 1'b1; idle(1); start_rdy = 1'b0;
    check("lit031_drained", {31'd0, start_vld}, 0);

    // 6 then 2 -> 4 with consumer always ready
    start_rdy = 1'b1;
    send(6, 1);
    check("lit032_start6", {24'd0, start}, 6);
    send(2, 0);
    check("lit032_empty", {31'd0, start_vld}, 0);
    send(4, 1);
    check("lit032_start2", {24'd0, start}, 2);
    idle(1);
    lit_link(6, 0); lit_link(2, 4); lit_link(4, 0);
    start_rdy = 1'b0;

    // Fill the head FIFO, hold the fifth list, release one slot
    send(1, 1); send(2, 1); send(3, 1); send(5, 1);
    check("lit033_full", {31'd0, in_rdy}, 0);
    send(9, 1); send(9, 1);
    check("lit033_start1", {24'd0, start}, 1);
    start_rdy = 1'b1;
    cycle();
    check("lit033_rdy_again", {31'd0, in_rdy}, 1);
    check("lit033_start2", {24'd0, start}, 2);
    start_rdy = 1'b0;
    cycle();
    check("lit033_full2", {31'd0, in_rdy}, 0);
    check("lit033_still2", {24'd0, start}, 2);
    in_vld = 1'b0;
    start_rdy = 1'b1; idle(5); start_rdy = 1'b0;
    check("lit033_drained", {31'd0, start_vld}, 0);

    // Null pointer inside an open list
    send(3, 0); send(0, 0);
    check("lit034_err", {31'd0, err_null}, 1);
    send(10, 1);
    check("lit034_err_clear", {31'd0, err_null}, 0);
    check("lit034_start", {24'd0, start}, 3);
    in_vld = 1'b0;
    lit_link(3, 10); lit_link(10, 0);
    start_rdy = 1'b1; idle(1); start_rdy = 1'b0;

    // Null last node with no open list: flagged, nothing queued
    send(0, 1);
    check("lit_null_idle_err", {31'd0, err_null}, 1);
    check("lit_null_idle_vld", {31'd0, start_vld}, 0);
    idle(1);

    // Reset in the middle of an open list
    send(1, 0); send(5, 0);
    in_vld = 1'b0;
    lit_link(1, 5);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    send(3, 1);
    in_vld = 1'b0;
    check("lit035_start", {24'd0, start}, 3);
    lit_link(1, 0); lit_link(5, 0);
    start_rdy = 1'b1; idle(1); start_rdy = 1'b0;

    // Simultaneous pop and push with one head queued
    send(11, 1); send(12, 0);
    start_rdy = 1'b1;
    send(13, 1);
    check("lit036_start", {24'd0, start}, 12);
    check("lit036_vld", {31'd0, start_vld}, 1);
    idle(1);
    check("lit036_count1", {31'd0, start_vld}, 0);
    start_rdy = 1'b0;

    // Repeated node equal to the tail terminates itself
    send(14, 0); send(14, 0); send(14, 1);
    in_vld = 1'b0;
    lit_link(14, 0);
    check("lit_selftail_start", {24'd0, start}, 14);
    start_rdy = 1'b1; idle(1); start_rdy = 1'b0;

    // Mixed traffic with toggling consumer
    for (int i = 0; i < 24; i++) begin
      start_rdy = (i % 4) == 3;
      send((i % 15) + 1, (i % 3) == 2);
    end
    in_vld = 1'b0;
    start_rdy = 1'b1; idle(6); start_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ll_list_builder.md
LL_LIST_BUILDER -- requirements
Module: ll_list_builder

Interface
REQ-001 SHALL have parameter N, default 256, meaning number of list nodes; pointer 0 is the null pointer.
REQ-002 SHALL have parameter W_PTR, default $clog2(N), meaning pointer width.
REQ-003 SHALL have parameter HEAD_DEPTH, default 4, meaning completed-list head FIFO depth (power of 2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_ptr  input  W_PTR  node pointer to append to the open list.
REQ-007 in_last  input  1  in_ptr is the final node of the list.
REQ-008 in_vld  input  1  in_ptr/in_last valid.
REQ-009 in_rdy  output  1  block accepts in_ptr this cycle.
REQ-010 start  output  W_PTR  head pointer of oldest completed list.
REQ-011 start_vld  output  1  start valid.
REQ-012 start_rdy  input  1  consumer takes start this cycle.
REQ-013 rd_ptr  input  W_PTR  next-table lookup address.
REQ-014 rd_next  output  W_PTR  next[rd_ptr], combinational.
REQ-015 err_null  output  1  one-cycle pulse: a null in_ptr was accepted.

Function
REQ-016 Block SHALL hold next table next[0..N-1] of W_PTR bits; rd_next SHALL equal next[rd_ptr] combinationally, including next[0].
REQ-017 Accept = in_vld & in_rdy; in_rdy SHALL be ~full, full derived from registered FIFO count only (no same-cycle pop bypass).
REQ-018 FSM SHALL have states IDLE (no open list) and OPEN (list open; head and tail registers valid).
REQ-019 Accept of p!=0 in IDLE: next[p]<=0, head<=p, tail<=p; in_last=0 -> OPEN; in_last=1 -> push p to FIFO, stay IDLE.
REQ-020 Accept of p!=0 in OPEN: next[tail]<=p, next[p]<=0, tail<=p; in_last=1 -> push head, go IDLE; else stay OPEN.
REQ-021 If p==tail in OPEN, write next[p]<=0 SHALL take priority over next[tail]<=p.
REQ-022 Accept of p==0: no table write, head/tail unchanged, err_null SHALL be 1 in the following cycle; with in_last=1 in OPEN, head SHALL still be pushed and state SHALL go IDLE; with in_last=1 in IDLE, nothing is pushed.
REQ-023 Table writes SHALL be visible on rd_next in the cycle after acceptance.
REQ-024 Head FIFO: start_vld = (count!=0); start = oldest entry when start_vld=1, else 0.
REQ-025 Pop on start_vld & start_rdy; start_rdy with start_vld=0 SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order; read/write indices SHALL wrap modulo HEAD_DEPTH.
REQ-027 Push never occurs when full (guaranteed by REQ-017); push into empty FIFO SHALL make start_vld=1 the next cycle.
REQ-028 A completed list's head SHALL appear on start no earlier than the cycle after its last-node acceptance, so all its links are already readable via rd_next.

Reset
REQ-029 On rst: state IDLE, head=tail=0, FIFO count and indices 0, start_vld=0, start=0, err_null=0, in_rdy=1 after release, all next[] = 0.
REQ-030 rst asserted mid-list SHALL discard the open list and its links (table cleared); no head pushed.

Verification
REQ-031 Send 7,15,8(last) back-to-back, start_rdy=0 -> next[7]=15, next[15]=8, next[8]=0; start=7, start_vld=1 the cycle after 8 accepted.
REQ-032 Send 6(last) then 2,4(last) with start_rdy=1 -> start sequence 6 then 2; next[6]=0, next[2]=4, next[4]=0.
REQ-033 Five single-node lists 1,2,3,5,9 (each last) with start_rdy=0 -> in_rdy=0 after 4th accept, 5th held; pulse start_rdy one cycle -> start=1 popped, in_rdy=1 next cycle, 9 accepted; start then shows 2.
REQ-034 Send 3, then 0 (not last), then 10(last) -> err_null one pulse after 0 accept; next[3]=10, next[10]=0, start=3.
REQ-035 Send 1,5 then assert rst 2 cycles, then 3(last) -> next[1]=next[5]=0, start=3, no head 1 ever emitted.
REQ-036 With FIFO holding one head, pop and last-node push in same cycle -> count stays 1, start shows new head next cycle.
